// File: rtl/path_traceback.sv
// Direction-map traceback: walks plot codes from the goal cell back to
// the origin, streaming each visited coordinate over a valid/ready port.
module path_traceback #(
  parameter int XW     = 4,
  parameter int YW     = 4,
  parameter int XMAX   = 15,
  parameter int YMAX   = 15,
  parameter int MAXLEN = 255
) (
  input  logic          m_clock,
  input  logic          p_reset,
  input  logic          trace_exe,
  input  logic [XW-1:0] goal_x,
  input  logic [YW-1:0] goal_y,
  output logic          mem_rd,
  output logic [XW+YW-1:0] mem_addr,
  input  logic [7:0]    mem_data,
  output logic          out_valid,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [7:0]    path_len
);

  typedef enum logic [2:0] {
    IDLE, RD, WT, EMIT, DONE, ERR
  } state_t;

  state_t        state, state_nxt;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic [7:0]    code;
  logic [7:0]    len;
  logic          accept;
  logic          off_grid;

  assign accept = out_valid & out_ready;

  always_comb begin
    off_grid = 1'b0;
    case (mem_data)
      8'd1: off_grid = (cur_y == '0);
      8'd2: off_grid = (cur_y == YW'(YMAX));
      8'd3: off_grid = (cur_x == '0);
      8'd4: off_grid = (cur_x == XW'(XMAX));
      default: off_grid = 1'b0;
    endcase
  end

  always_ff @(posedge m_clock) begin
    if (!p_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (trace_exe) state_nxt = RD;
      RD:   state_nxt = WT;
      WT: begin
        if (mem_data > 8'd4)
          state_nxt = ERR;
        else if (off_grid)
          state_nxt = ERR;
        else if (mem_data != 8'd0 &&
                 len == 8'(MAXLEN))
          state_nxt = ERR;
        else
          state_nxt = EMIT;
      end
      EMIT: begin
        if (accept)
          state_nxt = (code == 8'd0) ? DONE : RD;
      end
      DONE: state_nxt = IDLE;
      ERR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge m_clock) begin
    if (!p_reset) begin
      cur_x <= '0;
      cur_y <= '0;
      code  <= '0;
      len   <= '0;
    end else begin
      if (state == IDLE && trace_exe) begin
        cur_x <= goal_x;
        cur_y <= goal_y;
        len   <= '0;
      end
      if (state == WT) code <= mem_data;
      // step toward the predecessor once the cell is consumed
      if (state == EMIT && accept) begin
        len <= len + 8'd1;
        case (code)
          8'd1: cur_y <= cur_y - YW'(1);
          8'd2: cur_y <= cur_y + YW'(1);
          8'd3: cur_x <= cur_x - XW'(1);
          8'd4: cur_x <= cur_x + XW'(1);
          default: ;
        endcase
      end
    end
  end

  assign busy      = (state != IDLE);
  assign mem_rd    = (state == RD);
  assign mem_addr  = mem_rd ? {cur_y, cur_x} : '0;
  assign out_valid = (state == EMIT);
  assign out_x     = out_valid ? cur_x : '0;
  assign out_y     = out_valid ? cur_y : '0;
  assign out_last  = out_valid && (code == 8'd0);
  assign done      = (state == DONE);
  assign err       = (state == ERR);
  assign path_len  = len;

endmodule

// File: tb/tb_path_traceback.sv
// Directed bench for path_traceback with a 16x16 map RAM model
// and a negedge monitor of accepted cells and status pulses.
module tb_path_traceback;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trace_exe;
  logic [3:0] goal_x, goal_y;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       out_valid;
  logic [3:0] out_x, out_y;
  logic       out_last;
  logic       out_ready;
  logic       busy, done, err;
  logic [7:0] path_len;

  logic [7:0] map [256];
  logic [8:0] cells [$];
  int rd_cnt   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int total    = 0;
  int passed   = 0;

  always #5 clk = ~clk;

  path_traceback dut (
    .m_clock  (clk),
    .p_reset  (rst_n),
    .trace_exe(trace_exe),
    .goal_x   (goal_x),
    .goal_y   (goal_y),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .out_valid(out_valid),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .path_len (path_len)
  );

  always @(posedge clk)
    if (mem_rd) mem_data <= map[mem_addr];

  always @(negedge clk) begin
    if (out_valid && out_ready)
      cells.push_back({out_x, out_y, out_last});
    if (mem_rd) rd_cnt++;
    if (done)   done_cnt++;
    if (err)    err_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [3:0] x,
                       input logic [3:0] y);
    goal_x    = x;
    goal_y    = y;
    trace_exe = 1'b1;
    tick();
    trace_exe = 1'b0;
  endtask

  task automatic wait_end(input string tag,
                          input int budget);
    int n = 0;
    while (!(done || err) && n < budget) begin
      tick();
      n++;
    end
    if (!(done || err))
      check({tag, "_timeout"}, 0, 1);
    tick();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid)
      check({tag, "_novalid"}, 0, 1);
  endtask

  task automatic clear_map;
    for (int i = 0; i < 256; i++) map[i] = 8'd7;
  endtask

  int qb, db, eb, rb, bad;
  logic [8:0] exp_c, held;

  initial begin
    rst_n     = 1'b0;
    trace_exe = 1'b0;
    goal_x    = '0;
    goal_y    = '0;
    out_ready = 1'b1;
    mem_data  = '0;
    clear_map();
    map[8'h53] = 8'd1;
    map[8'h43] = 8'd1;
    map[8'h33] = 8'd0;
    map[8'h77] = 8'd0;
    map[8'h20] = 8'd3;
    map[8'h0F] = 8'd4;
    map[8'h95] = 8'd9;
    map[8'h11] = 8'd4;
    map[8'h12] = 8'd3;

    tick(); tick(); tick();
    check("rst_busy",  busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_rd",    mem_rd, 0);
    check("rst_len",   path_len, 0);
    check("rst_done",  done | err, 0);
    rst_n = 1'b1;
    tick();

    // straight path with latency checks
    qb = cells.size(); db = done_cnt; eb = err_cnt;
    start(4'd3, 4'd5);
    check("lat_rd",   mem_rd, 1);
    check("lat_addr", mem_addr, 8'h53);
    tick();
    check("lat_wt", out_valid, 0);
    tick();
    check("lat_valid", out_valid, 1);
    check("lat_xy", {out_x, out_y}, 8'h35);
    wait_end("straight", 30);
    check("st_n", cells.size() - qb, 3);
    if (cells.size() - qb == 3) begin
      check("st_c0", cells[qb],   {4'd3, 4'd5, 1'b0});
      check("st_c1", cells[qb+1], {4'd3, 4'd4, 1'b0});
      check("st_c2", cells[qb+2], {4'd3, 4'd3, 1'b1});
    end
    check("st_done", done_cnt - db, 1);
    check("st_err",  err_cnt - eb, 0);
    check("st_len",  path_len, 3);
    check("st_idle", busy, 0);

    // zero-length
    qb = cells.size(); db = done_cnt;
    start(4'd7, 4'd7);
    wait_end("zero", 20);
    check("z_n", cells.size() - qb, 1);
    if (cells.size() - qb == 1)
      check("z_c0", cells[qb], {4'd7, 4'd7, 1'b1});
    check("z_done", done_cnt - db, 1);
    check("z_len",  path_len, 1);

    // backpressure
    qb = cells.size(); db = done_cnt; rb = rd_cnt;
    out_ready = 1'b0;
    start(4'd3, 4'd5);
    for (int k = 0; k < 3; k++) begin
      wait_valid("bp");
      exp_c = {4'd3, 4'(5 - k), 1'(k == 2)};
      held  = {out_x, out_y, out_last};
      check("bp_cell", held, exp_c);
      bad = 0;
      for (int j = 0; j < 4; j++) begin
        tick();
        if (!out_valid || {out_x, out_y, out_last} != held)
          bad++;
      end
      check("bp_hold", bad, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    wait_end("bp", 20);
    out_ready = 1'b1;
    check("bp_n",    cells.size() - qb, 3);
    check("bp_rd",   rd_cnt - rb, 3);
    check("bp_done", done_cnt - db, 1);
    check("bp_len",  path_len, 3);

    // left edge
    qb = cells.size(); eb = err_cnt; db = done_cnt;
    start(4'd0, 4'd2);
    wait_end("edge0", 20);
    check("e0_err",  err_cnt - eb, 1);
    check("e0_n",    cells.size() - qb, 0);
    check("e0_len",  path_len, 0);
    check("e0_done", done_cnt - db, 0);

    // right edge
    eb = err_cnt;
    start(4'd15, 4'd0);
    wait_end("edgex", 20);
    check("ex_err", err_cnt - eb, 1);

    // illegal code
    qb = cells.size(); eb = err_cnt;
    start(4'd5, 4'd9);
    wait_end("ill", 20);
    check("il_err", err_cnt - eb, 1);
    check("il_n",   cells.size() - qb, 0);

    // loop guard
    qb = cells.size(); eb = err_cnt; db = done_cnt;
    start(4'd1, 4'd1);
    wait_end("loop", 1000);
    check("lp_n", cells.size() - qb, 255);
    bad = 0;
    for (int i = 0; i < 255 && qb + i < cells.size(); i++) begin
      exp_c = (i % 2 == 0) ? {4'd1, 4'd1, 1'b0}
                           : {4'd2, 4'd1, 1'b0};
      if (cells[qb+i] != exp_c) bad++;
    end
    check("lp_seq",  bad, 0);
    check("lp_err",  err_cnt - eb, 1);
    check("lp_done", done_cnt - db, 0);
    check("lp_len",  path_len, 255);

    // trace_exe while busy is ignored
    qb = cells.size(); db = done_cnt;
    start(4'd3, 4'd5);
    tick(); tick();
    goal_x = 4'd9; goal_y = 4'd9;
    trace_exe = 1'b1;
    tick(); tick();
    trace_exe = 1'b0;
    wait_end("ign", 30);
    check("ig_n", cells.size() - qb, 3);
    if (cells.size() - qb == 3)
      check("ig_c2", cells[qb+2], {4'd3, 4'd3, 1'b1});
    check("ig_done", done_cnt - db, 1);
    check("ig_len",  path_len, 3);
    tick();
    check("ig_idle", busy, 0);

    // reset mid-EMIT
    start(4'd3, 4'd5);
    wait_valid("mr");
    out_ready = 1'b0;
    tick();
    wait_valid("mr2");
    check("mr_pre", path_len, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_valid("mr3");
    check("mr_len1", path_len, 1);
    rst_n = 1'b0;
    tick();
    check("mr_valid", out_valid, 0);
    check("mr_busy",  busy, 0);
    check("mr_len",   path_len, 0);
    check("mr_addr",  {mem_rd, mem_addr}, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // normal run after reset
    qb = cells.size(); db = done_cnt;
    start(4'd7, 4'd7);
    wait_end("post", 20);
    check("po_n",    cells.size() - qb, 1);
    check("po_done", done_cnt - db, 1);
    check("po_len",  path_len, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
